// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler driving the S/En pins of a shared 4:1 mux, with a one-cycle
// break-before-make gap between owners. Optional hold timeout under MUX4_SCHED_TIMEOUT_EN.
module mux4_rr_sched #(
    parameter int MAX_HOLD = 8
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [3:0] Req,
    input  logic       Done,
    output logic [1:0] S,
    output logic       En,
    output logic [3:0] Gnt,
    output logic       Busy,
    output logic       Tmo
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t     state;
    logic [1:0] last;
    logic [1:0] win;
    logic [1:0] idx;
    logic       tmo_hit;
    logic       rel;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux4_rr_sched: MAX_HOLD must be in 2..255");
    end

`ifdef MUX4_SCHED_TIMEOUT_EN
    logic [7:0] hold_cnt;
    assign tmo_hit = (hold_cnt == 8'(MAX_HOLD));
`else
    assign tmo_hit = 1'b0;
    assign Tmo     = 1'b0;
`endif

    // Scan from last+4 down to last+1 so the nearest requester after last wins;
    // last+4 == last, which gives the previous owner lowest priority.
    always_comb begin
        win = last;
        idx = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (Req[idx]) win = idx;
        end
    end

    assign rel = Done | ~Req[S] | tmo_hit;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state <= IDLE;
            S     <= 2'b00;
            En    <= 1'b1;
            Gnt   <= 4'b0000;
            Busy  <= 1'b0;
            last  <= 2'd3;
`ifdef MUX4_SCHED_TIMEOUT_EN
            hold_cnt <= 8'd0;
            Tmo      <= 1'b0;
`endif
        end else begin
`ifdef MUX4_SCHED_TIMEOUT_EN
            Tmo <= 1'b0;
`endif
            case (state)
                GRANT: begin
                    if (rel) begin
                        state <= GAP;
                        Gnt   <= 4'b0000;
                        En    <= 1'b1;
`ifdef MUX4_SCHED_TIMEOUT_EN
                        // Pulse only when the timeout alone ended the grant.
                        Tmo <= tmo_hit & ~Done & Req[S];
`endif
                    end
`ifdef MUX4_SCHED_TIMEOUT_EN
                    if (!rel && hold_cnt != 8'(MAX_HOLD)) hold_cnt <= hold_cnt + 8'd1;
`endif
                end
                default: begin
                    if (|Req) begin
                        state <= GRANT;
                        S     <= win;
                        Gnt   <= 4'b0001 << win;
                        En    <= 1'b0;
                        Busy  <= 1'b1;
                        last  <= win;
`ifdef MUX4_SCHED_TIMEOUT_EN
                        hold_cnt <= 8'd1;
`endif
                    end else begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Directed bench for mux4_rr_sched: each step drives inputs, queues the expected
// registered outputs, and checks them just after the next rising edge.
module tb_mux4_rr_sched;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic [3:0] Req = 4'b0000;
    logic       Done = 1'b0;
    logic [1:0] S;
    logic       En;
    logic [3:0] Gnt;
    logic       Busy;
    logic       Tmo;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] s;
        logic       en;
        logic [3:0] gnt;
        logic       busy;
        logic       tmo;
    } obs_t;

    typedef struct {
        obs_t  v;
        string tag;
    } exp_t;

    exp_t sb[$];

    mux4_rr_sched #(.MAX_HOLD(4)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Done(Done),
        .S(S), .En(En), .Gnt(Gnt), .Busy(Busy), .Tmo(Tmo)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic rst, input logic [3:0] req, input logic done,
                        input logic [1:0] s, input logic en, input logic [3:0] gnt,
                        input logic busy, input logic tmo, input string tag);
        exp_t e;
        obs_t o;
        Rst_n = rst;
        Req   = req;
        Done  = done;
        e.v   = '{s: s, en: en, gnt: gnt, busy: busy, tmo: tmo};
        e.tag = tag;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        o = '{s: S, en: En, gnt: Gnt, busy: Busy, tmo: Tmo};
        e = sb.pop_front();
        checks++;
        assert (o === e.v) else begin
            errors++;
            $error("FAIL %s: S/En/Gnt/Busy/Tmo got %b/%b/%b/%b/%b expected %b/%b/%b/%b/%b",
                   e.tag, o.s, o.en, o.gnt, o.busy, o.tmo,
                   e.v.s, e.v.en, e.v.gnt, e.v.busy, e.v.tmo);
        end
    endtask

    // Shorthands: granted to owner i, gap after owner i, idle with select s.
    task automatic grant(input logic [3:0] req, input logic done, input logic [1:0] i, input string tag);
        step(1'b1, req, done, i, 1'b0, 4'b0001 << i, 1'b1, 1'b0, tag);
    endtask

    task automatic gap(input logic [3:0] req, input logic done, input logic [1:0] i,
                       input logic tmo, input string tag);
        step(1'b1, req, done, i, 1'b1, 4'b0000, 1'b1, tmo, tag);
    endtask

    task automatic idle(input logic [3:0] req, input logic done, input logic [1:0] s, input string tag);
        step(1'b1, req, done, s, 1'b1, 4'b0000, 1'b0, 1'b0, tag);
    endtask

    initial begin
        // Reset then idle
        step(1'b0, 4'b0000, 1'b0, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b0, "reset0");
        step(1'b0, 4'b0000, 1'b0, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b0, "reset1");
        idle(4'b0000, 1'b0, 2'b00, "idle0");
        idle(4'b0000, 1'b0, 2'b00, "idle1");
        idle(4'b0000, 1'b1, 2'b00, "done_in_idle");

        // Single request, released by Done
        grant(4'b0100, 1'b0, 2'd2, "single_grant");
        gap(4'b0100, 1'b1, 2'd2, 1'b0, "single_gap");
        idle(4'b0000, 1'b0, 2'd2, "single_idle");

        // Reset mid-grant drops the grant at once and restores the pointer
        grant(4'b0100, 1'b0, 2'd2, "midrst_grant");
        step(1'b0, 4'b0100, 1'b0, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b0, "midrst_reset");

        // Round-robin with all requesting: first owner after reset is 0
        for (int k = 0; k < 5; k++) begin
            grant(4'b1111, 1'b0, 2'(k % 4), "rr_grant");
            grant(4'b1111, 1'b0, 2'(k % 4), "rr_hold");
            gap(4'b1111, 1'b1, 2'(k % 4), 1'b0, "rr_gap");
        end
        idle(4'b0000, 1'b0, 2'd0, "rr_idle");

        // Owner 1 drops while 3 rises; 3 then re-wins as sole requester
        grant(4'b0010, 1'b0, 2'd1, "sim_grant1");
        grant(4'b0010, 1'b0, 2'd1, "sim_hold1");
        gap(4'b1000, 1'b0, 2'd1, 1'b0, "sim_gap");
        grant(4'b1000, 1'b0, 2'd3, "sim_grant3");
        gap(4'b1000, 1'b1, 2'd3, 1'b0, "sim_gap3");
        grant(4'b1000, 1'b0, 2'd3, "sim_regrant3");
        gap(4'b0000, 1'b0, 2'd3, 1'b0, "sim_drop3");
        idle(4'b0000, 1'b0, 2'd3, "sim_idle");
        idle(4'b0000, 1'b1, 2'd3, "sim_done_idle");

        // Single persistent requester 0, Done never asserted
        for (int k = 0; k < 4; k++) grant(4'b0001, 1'b0, 2'd0, "hold_first4");
`ifdef MUX4_SCHED_TIMEOUT_EN
        gap(4'b0001, 1'b0, 2'd0, 1'b1, "tmo_gap");
        grant(4'b0001, 1'b0, 2'd0, "tmo_regrant");
        for (int k = 0; k < 3; k++) grant(4'b0001, 1'b0, 2'd0, "tmo_hold");
        gap(4'b0001, 1'b1, 2'd0, 1'b0, "tmo_with_done");
        idle(4'b0000, 1'b0, 2'd0, "tmo_idle");
`else
        for (int k = 0; k < 20; k++) grant(4'b0001, 1'b0, 2'd0, "hold_long");
        gap(4'b0000, 1'b0, 2'd0, 1'b0, "hold_drop_gap");
        idle(4'b0000, 1'b0, 2'd0, "hold_idle");
`endif

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
